// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
// Module      : present_pkg
// Description : Shared widths, FSM state type and the PRESENT bit
//               permutation used by the iterative round core.
// Revision    : 1.0 - initial release
// ============================================================================
package present_pkg;

    localparam int BLOCK_W = 64;
    localparam int ROUNDS  = 31;
    localparam int RK_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_t;

    // PRESENT pLayer: bit i lands on bit (16*i) mod 63, the MSB stays put.
    function automatic logic [BLOCK_W-1:0] player(input logic [BLOCK_W-1:0] din);
        logic [BLOCK_W-1:0] dout;
        dout = '0;
        for (int i = 0; i < BLOCK_W - 1; i++) begin
            dout[(16 * i) % 63] = din[i];
        end
        dout[BLOCK_W-1] = din[BLOCK_W-1];
        return dout;
    endfunction

endpackage
`default_nettype wire

// File: rtl/present_sbox.sv
`default_nettype none
// ============================================================================
// Module      : present_sbox
// Description : PRESENT 4-bit substitution box, purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module present_sbox (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    // Fixed PRESENT substitution table
    always_comb begin
        o_nibble = 4'h0;
        case (i_nibble)
            4'h0: o_nibble = 4'hC;
            4'h1: o_nibble = 4'h5;
            4'h2: o_nibble = 4'h6;
            4'h3: o_nibble = 4'hB;
            4'h4: o_nibble = 4'h9;
            4'h5: o_nibble = 4'h0;
            4'h6: o_nibble = 4'hA;
            4'h7: o_nibble = 4'hD;
            4'h8: o_nibble = 4'h3;
            4'h9: o_nibble = 4'hE;
            4'hA: o_nibble = 4'hF;
            4'hB: o_nibble = 4'h8;
            4'hC: o_nibble = 4'h4;
            4'hD: o_nibble = 4'h7;
            4'hE: o_nibble = 4'h1;
            4'hF: o_nibble = 4'h2;
            default: o_nibble = 4'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/present_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module      : present_sbox_layer
// Description : 64-bit PRESENT sBoxLayer, 16 parallel 4-bit S-boxes on
//               nibbles [4i+3:4i]. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module present_sbox_layer
    import present_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    output logic [BLOCK_W-1:0] o_state
);

    localparam int c_NIBBLES = BLOCK_W / 4;

    generate
        for (genvar g = 0; g < c_NIBBLES; g++) begin : g_nibble
            present_sbox u_sbox (
                .i_nibble (i_state[4*g +: 4]),
                .o_nibble (o_state[4*g +: 4])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/present_round_core.sv
`default_nettype none
// ============================================================================
// Module      : present_round_core
// Description : Iterative PRESENT-style 64-bit encryption datapath, one
//               round per clock. Owns the key state and round counter; the
//               combinational key schedule sits beside it at the parent
//               level and returns key_next.
// Revision    : 1.0 - initial release
// ============================================================================
module present_round_core
    import present_pkg::*;
#(
    parameter int KEY_SIZE = 80,
    parameter int ROUNDS   = present_pkg::ROUNDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                ready,
    input  logic [BLOCK_W-1:0]  plaintext,
    input  logic [KEY_SIZE-1:0] key,
    output logic [KEY_SIZE-1:0] key_cur,
    output logic [4:0]          key_round,
    input  logic [KEY_SIZE-1:0] key_next,
    output logic [BLOCK_W-1:0]  ciphertext,
    output logic                done
);

    // The 5-bit counter tops out at ROUNDS, so ROUNDS must stay below 32.
    localparam logic [4:0] c_LAST_ROUND = 5'(ROUNDS);

    state_t             r_state;
    logic [BLOCK_W-1:0] r_block;

    logic [RK_W-1:0]    w_rk;
    logic [BLOCK_W-1:0] w_sbox_in;
    logic [BLOCK_W-1:0] w_sbox_out;
    logic [BLOCK_W-1:0] w_round_out;

    // Round key is always the top 64 bits of the current key state.
    assign w_rk        = key_cur[KEY_SIZE-1 -: RK_W];
    assign w_sbox_in   = r_block ^ w_rk;
    assign w_round_out = player(w_sbox_out);

    present_sbox_layer u_sbox_layer (
        .i_state (w_sbox_in),
        .o_state (w_sbox_out)
    );

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_block    <= '0;
            key_cur    <= '0;
            key_round  <= 5'd0;
            ciphertext <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_block   <= plaintext;
                        key_cur   <= key;
                        key_round <= 5'd1;
                        ready     <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_block <= w_round_out;
                    key_cur <= key_next;
                    // Last full round: counter parks at 0 instead of
                    // running past ROUNDS.
                    if (key_round == c_LAST_ROUND) begin
                        key_round <= 5'd0;
                        r_state   <= FINAL;
                    end else begin
                        key_round <= key_round + 5'd1;
                    end
                end
                FINAL: begin
                    // key_cur now holds round key 32 for the final whitening.
                    ciphertext <= r_block ^ w_rk;
                    done       <= 1'b1;
                    key_round  <= 5'd0;
                    ready      <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    key_round <= 5'd0;
                    ready     <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_present_round_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_present_round_core
// Description : Self-checking bench for present_round_core. An 80-bit build
//               is paired with a behavioural PRESENT-80 key schedule; a
//               128-bit build is paired with an identity schedule stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_present_round_core;

    localparam int c_TIMEOUT = 64;
    localparam logic [3:0] c_SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic clk;
    logic rst;

    logic        start80, ready80, done80;
    logic [63:0] pt80, ct80;
    logic [79:0] key80, key_cur80, key_next80;
    logic [4:0]  key_round80;

    logic         start128, ready128, done128;
    logic [63:0]  pt128, ct128;
    logic [127:0] key128, key_cur128, key_next128;
    logic [4:0]   key_round128;

    int errors;
    int checks;

    logic [4:0] kr_trace  [0:c_TIMEOUT];
    logic       rdy_trace [0:c_TIMEOUT];

    present_round_core #(.KEY_SIZE(80)) dut80 (
        .clk        (clk),
        .rst        (rst),
        .start      (start80),
        .ready      (ready80),
        .plaintext  (pt80),
        .key        (key80),
        .key_cur    (key_cur80),
        .key_round  (key_round80),
        .key_next   (key_next80),
        .ciphertext (ct80),
        .done       (done80)
    );

    present_round_core #(.KEY_SIZE(128)) dut128 (
        .clk        (clk),
        .rst        (rst),
        .start      (start128),
        .ready      (ready128),
        .plaintext  (pt128),
        .key        (key128),
        .key_cur    (key_cur128),
        .key_round  (key_round128),
        .key_next   (key_next128),
        .ciphertext (ct128),
        .done       (done128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_round(input logic [63:0] s);
        logic [63:0] t;
        logic [63:0] p;
        for (int i = 0; i < 16; i++) t[4*i +: 4] = c_SBOX[s[4*i +: 4]];
        p = '0;
        for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16 * i) % 63] = t[i];
        return p;
    endfunction

    function automatic logic [79:0] ref_ks80(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = c_SBOX[r[79:76]];
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

    function automatic logic [63:0] ref_enc80(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s;
        logic [79:0] ks;
        s  = pt;
        ks = k;
        for (int r = 1; r <= 31; r++) begin
            s  = ref_round(s ^ ks[79:16]);
            ks = ref_ks80(ks, 5'(r));
        end
        return s ^ ks[79:16];
    endfunction

    function automatic logic [63:0] ref_enc128_const(input logic [63:0] pt, input logic [127:0] k);
        logic [63:0] s;
        s = pt;
        for (int r = 1; r <= 31; r++) s = ref_round(s ^ k[127:64]);
        return s ^ k[127:64];
    endfunction

    // Key schedule blocks that sit beside each core
    always_comb key_next80  = ref_ks80(key_cur80, key_round80);
    always_comb key_next128 = key_cur128;

    // ---------------- drivers ----------------
    task automatic run80(input logic [63:0] pt, input logic [79:0] k, output int lat);
        @(negedge clk);
        pt80 = pt; key80 = k; start80 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start80 = 1'b0;
        kr_trace[0]  = key_round80;
        rdy_trace[0] = ready80;
        lat = -1;
        for (int n = 1; n <= c_TIMEOUT && lat < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            kr_trace[n]  = key_round80;
            rdy_trace[n] = ready80;
            if (done80) lat = n;
        end
    endtask

    task automatic run128(input logic [63:0] pt, input logic [127:0] k, output int lat);
        @(negedge clk);
        pt128 = pt; key128 = k; start128 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start128 = 1'b0;
        lat = -1;
        for (int n = 1; n <= c_TIMEOUT && lat < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done128) lat = n;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({ready80, done80} !== 2'b10) begin errors++; $display("FAIL reset_hs80: got ready/done=%b required 10", {ready80, done80}); end
        checks++; if (ct80 !== 64'h0) begin errors++; $display("FAIL reset_ct80: got %h required 0", ct80); end
        checks++; if (key_cur80 !== 80'h0 || key_round80 !== 5'd0) begin errors++; $display("FAIL reset_key80: got key_cur=%h round=%0d required 0/0", key_cur80, key_round80); end
        checks++; if ({ready128, done128} !== 2'b10 || ct128 !== 64'h0 || key_round128 !== 5'd0 || key_cur128 !== 128'h0) begin
            errors++; $display("FAIL reset_128: got ready=%b done=%b ct=%h round=%0d required 1/0/0/0", ready128, done128, ct128, key_round128);
        end
        rst = 1'b0;
    endtask

    task automatic test_kat_zero();
        int lat;
        bit ok;
        run80(64'h0, 80'h0, lat);
        checks++; if (ct80 !== 64'h5579C1387B228445) begin errors++; $display("FAIL kat_zero_ct: got %h required 5579c1387b228445", ct80); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL kat_zero_latency: got done %0d edges after accept, required 32", lat); end
        ok = 1'b1;
        for (int n = 0; n < 32; n++) if (rdy_trace[n] !== 1'b0) ok = 1'b0;
        if (rdy_trace[32] !== 1'b1) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL kat_zero_ready: got ready pattern wrong, required low E0..E31 and high with done"); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done80 !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got done=%b one cycle later, required 0", done80); end
    endtask

    task automatic test_kat_ones();
        int lat;
        int bad;
        logic [4:0] exp_kr;
        run80(64'hFFFF_FFFF_FFFF_FFFF, {80{1'b1}}, lat);
        checks++; if (ct80 !== 64'h3333DCD3213210D2) begin errors++; $display("FAIL kat_ones_ct: got %h required 3333dcd3213210d2", ct80); end
        bad = -1;
        for (int n = 0; n <= 32; n++) begin
            exp_kr = (n <= 30) ? 5'(n + 1) : 5'd0;
            if (bad < 0 && kr_trace[n] !== exp_kr) bad = n;
        end
        checks++; if (bad >= 0) begin errors++; $display("FAIL kat_ones_key_round: got %0d after edge %0d, required %0d", kr_trace[bad], bad, (bad <= 30) ? bad + 1 : 0); end
    endtask

    task automatic test_random80();
        int lat;
        logic [63:0] pt;
        logic [79:0] k;
        for (int t = 0; t < 6; t++) begin
            pt = {$urandom, $urandom};
            k  = {16'($urandom), $urandom, $urandom};
            run80(pt, k, lat);
            checks++; if (lat !== 32 || ct80 !== ref_enc80(pt, k)) begin
                errors++; $display("FAIL random80_%0d: got ct=%h lat=%0d required ct=%h lat=32", t, ct80, lat, ref_enc80(pt, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, ct_a, ct_b;
        logic [79:0] ka, kb;
        int dones, first, second;
        logic rdy_at_done, rdy_after;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        ka = {16'($urandom), $urandom, $urandom};
        kb = {16'($urandom), $urandom, $urandom};
        dones = 0; first = -1; second = -1;
        rdy_at_done = 1'b0; rdy_after = 1'b1; ct_a = '0; ct_b = '0;
        @(negedge clk);
        pt80 = a; key80 = ka; start80 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pt80 = b; key80 = kb;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done80) begin
                dones++;
                if (first < 0) begin first = n; ct_a = ct80; rdy_at_done = ready80; end
                else begin second = n; ct_b = ct80; end
            end
            if (n == 33) rdy_after = ready80;
            if (n == 39) start80 = 1'b0;
        end
        checks++; if (first !== 32 || ct_a !== ref_enc80(a, ka)) begin errors++; $display("FAIL b2b_first: got edge %0d ct=%h required edge 32 ct=%h", first, ct_a, ref_enc80(a, ka)); end
        checks++; if (rdy_at_done !== 1'b1 || rdy_after !== 1'b0) begin errors++; $display("FAIL b2b_ready: got ready with done=%b after E33=%b required 1/0", rdy_at_done, rdy_after); end
        checks++; if (second !== 65 || ct_b !== ref_enc80(b, kb)) begin errors++; $display("FAIL b2b_second: got edge %0d ct=%h required edge 65 ct=%h", second, ct_b, ref_enc80(b, kb)); end
        checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", dones); end
    endtask

    task automatic test_rst_mid();
        int lat;
        @(negedge clk);
        pt80 = {$urandom, $urandom}; key80 = {16'($urandom), $urandom, $urandom}; start80 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start80 = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        checks++; if (key_round80 !== 5'd15) begin errors++; $display("FAIL rst_mid_round: got %0d required 15", key_round80); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({ready80, done80} !== 2'b10 || ct80 !== 64'h0 || key_round80 !== 5'd0 || key_cur80 !== 80'h0) begin
            errors++; $display("FAIL rst_mid_outputs: got ready=%b done=%b ct=%h round=%0d required 1/0/0/0", ready80, done80, ct80, key_round80);
        end
        rst = 1'b0;
        run80(64'h0, 80'h0, lat);
        checks++; if (lat !== 32 || ct80 !== 64'h5579C1387B228445) begin errors++; $display("FAIL rst_mid_kat: got ct=%h lat=%0d required 5579c1387b228445 lat=32", ct80, lat); end
    endtask

    task automatic test_start_while_busy();
        int lat, dones, first;
        bit stable;
        logic [63:0] x, y, prev;
        logic [79:0] kx, ky;
        x  = {$urandom, $urandom};
        y  = {$urandom, $urandom};
        kx = {16'($urandom), $urandom, $urandom};
        ky = {16'($urandom), $urandom, $urandom};
        prev = ref_enc80(x, kx);
        run80(x, kx, lat);
        checks++; if (ct80 !== prev) begin errors++; $display("FAIL busy_prev_ct: got %h required %h", ct80, prev); end
        @(negedge clk);
        pt80 = y; key80 = ky; start80 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start80 = 1'b0;
        pt80 = {$urandom, $urandom};
        stable = 1'b1; dones = 0; first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n < 32 && ct80 !== prev) stable = 1'b0;
            if (done80) begin dones++; if (first < 0) first = n; end
            if (n == 32 && ct80 !== ref_enc80(y, ky)) stable = 1'b0;
            start80 = (n == 9);
        end
        checks++; if (!stable) begin errors++; $display("FAIL busy_ct_stable: got ciphertext change outside E32 or wrong result, required stable then %h", ref_enc80(y, ky)); end
        checks++; if (dones !== 1 || first !== 32) begin errors++; $display("FAIL busy_single_done: got %0d pulses first at %0d required 1 at 32", dones, first); end
    endtask

    task automatic test_key128();
        int lat;
        logic [63:0]  pt;
        logic [127:0] k;
        for (int t = 0; t < 4; t++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            run128(pt, k, lat);
            checks++; if (lat !== 32 || ct128 !== ref_enc128_const(pt, k)) begin
                errors++; $display("FAIL key128_%0d: got ct=%h lat=%0d required ct=%h lat=32", t, ct128, lat, ref_enc128_const(pt, k));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1;
        start80 = 1'b0; pt80 = '0; key80 = '0;
        start128 = 1'b0; pt128 = '0; key128 = '0;
        test_reset();
        test_kat_zero();
        test_kat_ones();
        test_random80();
        test_back_to_back();
        test_rst_mid();
        test_start_while_busy();
        test_key128();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
